// File: rtl/time_pkg.sv
// time_pkg: shared digit encoding, time-field slice positions and set-FSM states
package time_pkg;
  localparam logic [5:0] CHAR_ZERO = 6'd26;
  localparam int SEC_ONES = 0;
  localparam int SEC_TENS = 6;
  localparam int MIN_ONES = 12;
  localparam int MIN_TENS = 18;
  typedef enum logic [1:0] {RUN, SET_MIN, SET_SEC, COMMIT} state_t;
endpackage

// File: rtl/bcd_field_step.sv
// bcd_field_step: one up/down step of a two-digit coded field with wrap between 00 and max
module bcd_field_step #(
  parameter logic [5:0] CHAR_ZERO = 6'd26
) (
  input  logic [11:0] field,
  input  logic        up,
  input  logic        down,
  input  logic [3:0]  max_tens,
  input  logic [3:0]  max_ones,
  output logic [11:0] next
);
  logic [3:0] t, o, nt, no;
  logic at_max, at_zero;
  assign t = 4'(field[11:6] - CHAR_ZERO);
  assign o = 4'(field[5:0] - CHAR_ZERO);
  assign at_max = t == max_tens && o == max_ones;
  assign at_zero = t == 4'd0 && o == 4'd0;
  // carry/borrow moves between ones and tens; top and bottom of the range wrap
  always_comb begin
    nt = t;
    no = o;
    if (up && !down) begin
      nt = at_max ? 4'd0 : (o == 4'd9 ? t + 4'd1 : t);
      no = (at_max || o == 4'd9) ? 4'd0 : o + 4'd1;
    end else if (down && !up) begin
      nt = at_zero ? max_tens : (o == 4'd0 ? t - 4'd1 : t);
      no = at_zero ? max_ones : (o == 4'd0 ? 4'd9 : o - 4'd1);
    end
  end
  assign next = {CHAR_ZERO + 6'(nt), CHAR_ZERO + 6'(no)};
endmodule

// File: rtl/time_set_controller.sv
// time_set_controller: button-driven mm:ss set FSM in front of the time counter (TIME_SET_AUTO_REPEAT_EN adds held-button auto-repeat)
module time_set_controller
  import time_pkg::*;
#(
  parameter logic [5:0] CHAR_ZERO = time_pkg::CHAR_ZERO,
  parameter int TIMEOUT_CYCLES = 1000000000,
  parameter int BLINK_HALF = 25000000,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_up_held,
  input  logic        btn_down_held,
  input  logic [23:0] cur_time,
  output logic        run_en,
  output logic        load_en,
  output logic [23:0] load_time,
  output logic [23:0] display_time,
  output logic [3:0]  edit_mask,
  output logic        blink_on
);
  localparam int IW = $clog2(TIMEOUT_CYCLES);
  localparam int BW = $clog2(BLINK_HALF);
  state_t state;
  logic [23:0] shadow, captured, next_shadow;
  logic [11:0] min_nxt, sec_nxt;
  logic [IW-1:0] idle;
  logic [BW-1:0] blink_cnt;
  logic in_set, up_ev, dn_ev, rep_fire, activity, step, timeout;
  function automatic logic [5:0] norm(input logic [5:0] c, input logic [3:0] mx);
    return (c >= CHAR_ZERO && {1'b0, c} <= 7'(CHAR_ZERO) + 7'(mx)) ? c : CHAR_ZERO;
  endfunction
  assign captured = {norm(cur_time[MIN_TENS +: 6], 4'd9), norm(cur_time[MIN_ONES +: 6], 4'd9),
                     norm(cur_time[SEC_TENS +: 6], 4'd5), norm(cur_time[SEC_ONES +: 6], 4'd9)};
  assign in_set = state == SET_MIN || state == SET_SEC;
`ifdef TIME_SET_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY);
  logic [RW-1:0] rep;
  logic rep_up, rep_dn;
  assign rep_up = btn_up_held && !btn_down_held;
  assign rep_dn = btn_down_held && !btn_up_held;
  assign rep_fire = in_set && (rep_up || rep_dn) && rep == RW'(REPEAT_DELAY - 1);
  // hold time counter: first step after REPEAT_DELAY, then every REPEAT_PERIOD
  always_ff @(posedge clk or posedge reset)
    if (reset) rep <= '0;
    else if (!in_set || btn_mode || !(rep_up || rep_dn)) rep <= '0;
    else rep <= rep_fire ? RW'(REPEAT_DELAY - REPEAT_PERIOD) : rep + 1'b1;
  assign up_ev = btn_up || (rep_fire && rep_up);
  assign dn_ev = btn_down || (rep_fire && rep_dn);
`else
  logic unused_held;
  assign unused_held = btn_up_held ^ btn_down_held;
  assign rep_fire = 1'b0;
  assign up_ev = btn_up;
  assign dn_ev = btn_down;
`endif
  bcd_field_step #(.CHAR_ZERO(CHAR_ZERO)) u_min (
    .field(shadow[MIN_ONES +: 12]), .up(up_ev), .down(dn_ev),
    .max_tens(4'd9), .max_ones(4'd9), .next(min_nxt)
  );
  bcd_field_step #(.CHAR_ZERO(CHAR_ZERO)) u_sec (
    .field(shadow[SEC_ONES +: 12]), .up(up_ev), .down(dn_ev),
    .max_tens(4'd5), .max_ones(4'd9), .next(sec_nxt)
  );
  assign next_shadow = state == SET_MIN ? {min_nxt, shadow[11:0]} : {shadow[23:12], sec_nxt};
  assign activity = btn_mode || btn_up || btn_down || rep_fire;
  assign step = up_ev ^ dn_ev;
  assign timeout = !activity && idle == IW'(TIMEOUT_CYCLES - 1);
  assign display_time = state == RUN ? cur_time : shadow;
  assign load_time = shadow;
  // edit FSM with registered outputs; mode beats up/down, timeout drops the edit
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= RUN;
      run_en <= 1'b1;
      load_en <= 1'b0;
      shadow <= {4{CHAR_ZERO}};
      edit_mask <= 4'b0000;
      blink_on <= 1'b1;
      idle <= '0;
      blink_cnt <= '0;
    end else begin
      load_en <= 1'b0;
      case (state)
        RUN: if (btn_mode) begin
          state <= SET_MIN;
          shadow <= captured;
          run_en <= 1'b0;
          edit_mask <= 4'b1100;
          blink_on <= 1'b1;
          idle <= '0;
          blink_cnt <= '0;
        end
        SET_MIN, SET_SEC: if (btn_mode) begin
          state <= state == SET_MIN ? SET_SEC : COMMIT;
          edit_mask <= state == SET_MIN ? 4'b0011 : 4'b0000;
          load_en <= state == SET_SEC;
          blink_on <= 1'b1;
          idle <= '0;
          blink_cnt <= '0;
        end else if (timeout) begin
          state <= RUN;
          run_en <= 1'b1;
          edit_mask <= 4'b0000;
          blink_on <= 1'b1;
          idle <= '0;
          blink_cnt <= '0;
        end else begin
          idle <= activity ? '0 : idle + 1'b1;
          if (step) begin
            shadow <= next_shadow;
            blink_on <= 1'b1;
            blink_cnt <= '0;
          end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
            blink_on <= !blink_on;
            blink_cnt <= '0;
          end else blink_cnt <= blink_cnt + 1'b1;
        end
        COMMIT: begin
          state <= RUN;
          run_en <= 1'b1;
        end
        default: state <= RUN;
      endcase
    end
endmodule

// File: tb/tb_time_set_controller.sv
// tb_time_set_controller: directed table, corner sequences and random stimulus against a behavioural model
module tb_time_set_controller;
  localparam int TO = 50;
  localparam int BH = 4;
  localparam int RD = 8;
  localparam int RP = 3;
  logic clk = 0, reset = 1;
  logic btn_mode = 0, btn_up = 0, btn_down = 0, btn_up_held = 0, btn_down_held = 0;
  logic [23:0] cur_time = '0;
  logic run_en, load_en, blink_on;
  logic [23:0] load_time, display_time;
  logic [3:0] edit_mask;
  int pass_n = 0, total_n = 0;
  int ms, mins, secs, idle, sb, hcnt;

  time_set_controller #(.CHAR_ZERO(6'd26), .TIMEOUT_CYCLES(TO), .BLINK_HALF(BH),
                        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .btn_up_held(btn_up_held), .btn_down_held(btn_down_held), .cur_time(cur_time),
    .run_en(run_en), .load_en(load_en), .load_time(load_time), .display_time(display_time),
    .edit_mask(edit_mask), .blink_on(blink_on)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] enc(int mm, int ss);
    return {6'(26 + mm / 10), 6'(26 + mm % 10), 6'(26 + ss / 10), 6'(26 + ss % 10)};
  endfunction

  function automatic int dig(logic [5:0] c, int mx);
    int v = int'(c) - 26;
    return (v < 0 || v > mx) ? 0 : v;
  endfunction

  task automatic chk(string name, logic [23:0] got, logic [23:0] exp);
    total_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic model_reset;
    ms = 0; mins = 0; secs = 0; idle = 0; sb = 0; hcnt = 0;
  endtask

  // ms: 0 run, 1 minutes, 2 seconds, 3 commit; idle and sb count edges since activity / visible reset
  task automatic model_step(bit m, bit u, bit d, bit hu, bit hd, logic [23:0] cur);
    bit fire = 0, ue, de, act;
`ifdef TIME_SET_AUTO_REPEAT_EN
    if ((ms == 1 || ms == 2) && (hu ^ hd) && !m) begin
      hcnt++;
      fire = hcnt >= RD && (hcnt - RD) % RP == 0;
    end else hcnt = 0;
`endif
    ue = u || (fire && hu);
    de = d || (fire && hd);
    act = m || u || d || fire;
    if (ms == 0) begin
      if (m) begin
        mins = dig(cur[23:18], 9) * 10 + dig(cur[17:12], 9);
        secs = dig(cur[11:6], 5) * 10 + dig(cur[5:0], 9);
        ms = 1; idle = 0; sb = 0;
      end
    end else if (ms == 3) ms = 0;
    else if (m) begin
      ms++; idle = 0; sb = 0;
    end else begin
      idle = act ? 0 : idle + 1;
      if (idle == TO) ms = 0;
      else if (ue != de) begin
        if (ms == 1) mins = (mins + (ue ? 1 : 99)) % 100;
        else secs = (secs + (ue ? 1 : 59)) % 60;
        sb = 0;
      end else sb++;
    end
  endtask

  task automatic check_model;
    logic [3:0] em = ms == 1 ? 4'b1100 : ms == 2 ? 4'b0011 : 4'b0000;
    logic [23:0] ed = ms == 0 ? cur_time : enc(mins, secs);
    logic eb = (ms == 1 || ms == 2) ? ((sb / BH) % 2 == 0) : 1'b1;
    chk("model_run_en", 24'(run_en), 24'(ms == 0));
    chk("model_load_en", 24'(load_en), 24'(ms == 3));
    chk("model_edit_mask", 24'(edit_mask), 24'(em));
    chk("model_blink_on", 24'(blink_on), 24'(eb));
    chk("model_display", display_time, ed);
    if (ms == 3) chk("model_load_time", load_time, ed);
  endtask

  // called at a falling edge: drive one cycle of inputs, clock it, check at the next falling edge
  task automatic cyc(bit m, bit u, bit d);
    btn_mode = m; btn_up = u; btn_down = d;
    model_step(m, u, d, btn_up_held, btn_down_held, cur_time);
    @(posedge clk);
    @(negedge clk);
    btn_mode = 0; btn_up = 0; btn_down = 0;
    check_model();
  endtask

  task automatic do_reset;
    reset = 1;
    @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  typedef struct {
    logic m, u, d;
    logic run, load;
    logic [3:0] mask;
    logic [23:0] disp;
  } vec_t;
  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1100, enc(12, 34)};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1100, enc(13, 34)};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1100, enc(14, 34)};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, enc(14, 34)};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0011, enc(14, 33)};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, enc(14, 33)};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, enc(12, 34)};
    model_reset();
    cur_time = enc(12, 34);
    repeat (2) @(negedge clk);
    reset = 0;
    chk("reset_run_en", 24'(run_en), 24'd1);
    chk("reset_load_en", 24'(load_en), 24'd0);
    chk("reset_mask", 24'(edit_mask), 24'd0);
    chk("reset_blink", 24'(blink_on), 24'd1);
    chk("reset_display", display_time, enc(12, 34));
    // capture, edit, commit
    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].m, tbl[i].u, tbl[i].d);
      chk("vec_run_en", 24'(run_en), 24'(tbl[i].run));
      chk("vec_load_en", 24'(load_en), 24'(tbl[i].load));
      chk("vec_mask", 24'(edit_mask), 24'(tbl[i].mask));
      chk("vec_display", display_time, tbl[i].disp);
      if (tbl[i].load) chk("vec_load_time", load_time, tbl[i].disp);
    end
    // wrap-around at both ends of minutes and seconds
    do_reset();
    cur_time = enc(0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    chk("wrap_min_down", display_time, enc(99, 0));
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    chk("wrap_sec_down", display_time, enc(99, 59));
    cyc(0, 1, 0);
    chk("wrap_sec_up", display_time, enc(99, 0));
    cyc(1, 0, 0);
    chk("wrap_load_time", load_time, enc(99, 0));
    cyc(0, 0, 0);
    // illegal digits are captured as zero
    cur_time = {6'd40, 6'd27, 6'd33, 6'd5};
    cyc(1, 0, 0);
    chk("norm_capture", display_time, enc(1, 0));
    // timeout with blink phases along the way
    do_reset();
    cur_time = enc(5, 7);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    chk("to_step", display_time, enc(6, 7));
    for (int i = 1; i < TO; i++) begin
      cyc(0, 0, 0);
      if (i == 3) chk("blink_k3", 24'(blink_on), 24'd1);
      if (i == 4) chk("blink_k4", 24'(blink_on), 24'd0);
      if (i == 8) chk("blink_k8", 24'(blink_on), 24'd1);
    end
    chk("to_still_set", 24'(edit_mask), 24'b1100);
    cyc(0, 0, 0);
    chk("to_run_en", 24'(run_en), 24'd1);
    chk("to_mask", 24'(edit_mask), 24'd0);
    chk("to_display", display_time, enc(5, 7));
    cur_time = enc(8, 9);
    cyc(0, 1, 0);
    chk("to_follow_cur", display_time, enc(8, 9));
    // mode beats up; up+down is a no-op that still counts as activity
    do_reset();
    cur_time = enc(12, 34);
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    chk("sim_mode_mask", 24'(edit_mask), 24'b0011);
    chk("sim_mode_disp", display_time, enc(12, 34));
    repeat (45) cyc(0, 0, 0);
    cyc(0, 1, 1);
    chk("sim_updown_disp", display_time, enc(12, 34));
    repeat (TO - 1) cyc(0, 0, 0);
    chk("sim_idle_reset", 24'(edit_mask), 24'b0011);
    cyc(0, 0, 0);
    chk("sim_timeout", 24'(run_en), 24'd1);
    // asynchronous reset in the middle of an edit
    do_reset();
    cur_time = enc(1, 2);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    #2 reset = 1;
    #1;
    chk("areset_run_en", 24'(run_en), 24'd1);
    chk("areset_load_en", 24'(load_en), 24'd0);
    chk("areset_mask", 24'(edit_mask), 24'd0);
    chk("areset_display", display_time, enc(1, 2));
    @(negedge clk);
    reset = 0;
    model_reset();
`ifdef TIME_SET_AUTO_REPEAT_EN
    cur_time = enc(0, 10);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    btn_up_held = 1;
    for (int i = 1; i <= 20; i++) begin
      cyc(0, 0, 0);
      if (i == 7) chk("rep_before", display_time, enc(0, 10));
      if (i == 8) chk("rep_first", display_time, enc(0, 11));
    end
    chk("rep_final", display_time, enc(0, 15));
    btn_up_held = 0;
    do_reset();
`endif
    // random traffic alternating busy and quiet phases
    for (int i = 0; i < 4000; i++) begin
      int dens = ((i / 400) % 2) ? 4 : 90;
      if ($urandom_range(0, 7) == 0)
        cur_time = ($urandom_range(0, 3) == 0) ? 24'($urandom) : enc($urandom_range(0, 99), $urandom_range(0, 59));
      if ($urandom_range(0, 19) == 0) btn_up_held = !btn_up_held;
      if ($urandom_range(0, 29) == 0) btn_down_held = !btn_down_held;
      cyc($urandom_range(0, dens * 3) == 0, $urandom_range(0, dens - 1) == 0, $urandom_range(0, dens - 1) == 0);
    end
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/time_set_controller.md
Name: time_set_controller

Overview:
- Sequences the free-running mm:ss time counter so the user can set it from board buttons.
- Sits between the debounced button pulses and the counter's load/enable interface, and drives the display source and blink control.
- Captures the live time, runs a minutes-then-seconds edit FSM with wrap-around up/down, then commits the edited value with a one-cycle load strobe.
- Abandons the edit on inactivity timeout.

Parameters:
- CHAR_ZERO, 26: 6-bit character code for digit 0; digit d is encoded as CHAR_ZERO+d.
- TIMEOUT_CYCLES, 1000000000: idle cycles in an edit state before abandoning (10 s at 100 MHz).
- BLINK_HALF, 25000000: cycles per blink phase.
- REPEAT_DELAY, 50000000: hold time before auto-repeat starts (feature only).
- REPEAT_PERIOD, 10000000: cycles between auto-repeat steps (feature only).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- btn_mode  in  1  single-cycle pulse, debounced.
- btn_up  in  1  single-cycle pulse.
- btn_down  in  1  single-cycle pulse.
- btn_up_held  in  1  level, button held (auto-repeat only).
- btn_down_held  in  1  level, button held (auto-repeat only).
- cur_time  in  24  live counter value: [23:18] min tens, [17:12] min ones, [11:6] sec tens, [5:0] sec ones, each a digit code.
- run_en  out  1  counter count-enable.
- load_en  out  1  one-cycle load strobe to the counter.
- load_time  out  24  value to load; valid when load_en=1.
- display_time  out  24  cur_time in RUN, else the shadow register.
- edit_mask  out  4  per-field edit flags, bit3=min tens … bit0=sec ones.
- blink_on  out  1  blink phase; the display blanks masked fields when 0.

Behaviour:
- Reset (async, any state): state=RUN, run_en=1, load_en=0, shadow=all fields CHAR_ZERO, edit_mask=0, blink_on=1, all counters 0.
- States: RUN, SET_MIN, SET_SEC, COMMIT.
- RUN:
  - btn_mode: shadow<=normalised cur_time, run_en<=0, go SET_MIN.
  - btn_up/btn_down are ignored.
- SET_MIN (edit_mask=1100):
  - btn_up: minutes +1, 99 wraps to 00.
  - btn_down: minutes −1, 00 wraps to 99.
  - btn_mode: go SET_SEC.
- SET_SEC (edit_mask=0011):
  - btn_up: seconds +1, 59 wraps to 00.
  - btn_down: seconds −1, 00 wraps to 59.
  - btn_mode: go COMMIT.
- COMMIT (edit_mask=0000):
  - For exactly one cycle, load_en=1 and load_time=shadow.
  - Next cycle: RUN with run_en=1.
- Arithmetic: operate on BCD pairs (tens, ones) decoded as code−CHAR_ZERO, then re-encode; a carry or borrow crosses from ones into tens within the field.
- Normalisation on capture: any digit field outside its legal range (ones 0–9, sec tens 0–5, min tens 0–9) is captured as CHAR_ZERO.
- Same-cycle events:
  - btn_mode wins over up/down.
  - btn_up and btn_down together is a no-op, but still counts as activity.
- Timeout:
  - The idle counter clears on any button pulse and on state entry.
  - Reaching TIMEOUT_CYCLES−1 in SET_MIN or SET_SEC returns to RUN with run_en=1 and no load; shadow is discarded.
- Blink:
  - The blink counter runs only in the SET states; blink_on toggles every BLINK_HALF cycles.
  - blink_on is forced to 1 on entry to each SET state and on any up/down step, so edits stay visible.
  - In RUN and COMMIT, blink_on=1.
- Latency:
  - Button pulse to shadow/display update: 1 cycle.
  - Commit: 2 cycles after the SET_SEC btn_mode pulse, the counter is running again.
- Counter widths: each counter is sized by $clog2 of its parameter and must never overflow.

Optional Feature:
- Macro: TIME_SET_AUTO_REPEAT_EN.
- Defined:
  - In a SET state, holding btn_up_held (or btn_down_held) for REPEAT_DELAY cycles generates an internal step.
  - Further steps follow every REPEAT_PERIOD cycles while the level stays high.
  - Releasing the button or changing state clears the repeat counter.
  - Repeat steps count as activity for timeout.
- Undefined: btn_*_held are ignored and no repeat logic is synthesised.

Decomposition:
- Shared package time_pkg holds:
  - CHAR_ZERO;
  - field slice constants (SEC_ONES, SEC_TENS, MIN_ONES, MIN_TENS);
  - the state enum.
- One sub-module, bcd_field_step: takes a 12-bit two-digit code field, up, down and max tens/ones; outputs the wrapped next field. It is instantiated for minutes (max 99) and seconds (max 59).

Test Plan:
All scenarios use small parameters: BLINK_HALF=4, TIMEOUT_CYCLES=50, REPEAT_DELAY=8, REPEAT_PERIOD=3.
- Capture and commit: cur_time=12:34, then mode, up×2, mode, down×1, mode → load_en pulse once with load_time=14:33; run_en=0 throughout editing, then 1.
- Wrap: in SET_MIN from 00, down → 99. In SET_SEC from 59, up → 00; from 00, down → 59.
- Timeout: enter SET_MIN, up once, idle 50 cycles → RUN, run_en=1, load_en never asserted, display_time=cur_time.
- Simultaneous: mode+up in the same cycle in SET_MIN → SET_SEC, minutes unchanged. up+down together → no change, idle counter reset.
- Reset mid-edit: assert reset in SET_SEC → immediate RUN, run_en=1, load_en=0, edit_mask=0000.
- With the macro: hold btn_up_held 20 cycles in SET_SEC from 10 → steps at cycles 8, 11, 14, 17, 20 → seconds=15.
